// File: rtl/piso_shift_tx_pkg.sv
// Shared definitions for the serial shift transmit/receive pair:
// FSM state encoding, bit-order constants and counter sizing.
package piso_shift_tx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam bit BIT_ORDER_MSB_FIRST = 1'b1;
  localparam bit BIT_ORDER_LSB_FIRST = 1'b0;

  // Width of a counter that must hold WIDTH-1 down to 0 (at least one bit).
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_tx_bit_down_counter.sv
// Bit counter for one word: loads WIDTH-1 when a word is accepted and
// counts down once per shifted bit. o_zero marks the final bit of the word.
module piso_shift_tx_bit_down_counter
  import piso_shift_tx_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic          i_dec,
  output logic [CW-1:0] o_cnt,
  output logic          o_zero
);

  localparam logic [CW-1:0] LOAD_VAL = CW'(WIDTH - 1);

  logic [CW-1:0] r_cnt;

  // Load on word accept, otherwise decrement; the owner never decrements at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_dec) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter. A word is taken on load_valid & load_ready
// and sent one bit per enabled clock on so; a new word can be taken on the cycle
// the final bit is on so, giving a gapless stream.
//
// Handshake: a word transfers on the rising edge where load_valid and load_ready
// are both high. load_ready is combinational and only high while ce=1, out of
// reset, and the transmitter is idle or showing the last bit of a word. The
// source must hold load_valid/load_data stable until that edge.
module piso_shift_tx
  import piso_shift_tx_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             so,
  output logic             so_valid,
  output logic             last,
  output logic             busy,
  output state_t           dbg_state
);

  localparam int CW = cnt_width(WIDTH);
  localparam bit W_MSB = (MSB_FIRST == BIT_ORDER_MSB_FIRST);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic             r_so;
  logic             r_so_valid;
  logic [CW-1:0]    w_cnt;
  logic             w_cnt_zero;
  logic             w_in_shift;
  logic             w_accept;
  logic             w_dec;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_load_rest;
  logic [WIDTH-1:0] w_sreg_shifted;

  assign w_in_shift = (r_state == ST_SHIFT);
  // Reset also blocks acceptance so nothing is taken while rst is low.
  assign load_ready = rst & ce & (!w_in_shift | w_cnt_zero);
  assign w_accept   = load_valid & load_ready;
  assign w_dec      = ce & w_in_shift & !w_cnt_zero;

  // The first bit goes straight to so; the shift register keeps the rest,
  // aligned so the next bit always sits at the outgoing end.
  assign w_first_bit    = W_MSB ? load_data[WIDTH-1] : load_data[0];
  assign w_load_rest    = W_MSB ? (load_data << 1) : (load_data >> 1);
  assign w_next_bit     = W_MSB ? r_sreg[WIDTH-1] : r_sreg[0];
  assign w_sreg_shifted = W_MSB ? (r_sreg << 1) : (r_sreg >> 1);

  piso_shift_tx_bit_down_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst),
    .i_load (w_accept),
    .i_dec  (w_dec),
    .o_cnt  (w_cnt),
    .o_zero (w_cnt_zero)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: leave SHIFT only after the last bit with no follow-on word.
  always_comb begin
    w_state_nxt = r_state;
    if (ce) begin
      case (r_state)
        ST_IDLE:  if (w_accept) w_state_nxt = ST_SHIFT;
        ST_SHIFT: if (w_cnt_zero && !w_accept) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Serial datapath: load a word, shift the next bit, or return so to idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_so       <= IDLE_BIT;
      r_so_valid <= 1'b0;
      r_sreg     <= '0;
    end else if (w_accept) begin
      r_so       <= w_first_bit;
      r_so_valid <= 1'b1;
      r_sreg     <= w_load_rest;
    end else if (w_dec) begin
      r_so       <= w_next_bit;
      r_sreg     <= w_sreg_shifted;
    end else if (ce && w_in_shift) begin
      r_so       <= IDLE_BIT;
      r_so_valid <= 1'b0;
    end
  end

  assign so        = r_so;
  assign so_valid  = r_so_valid;
  assign last      = r_so_valid & w_cnt_zero;
  assign busy      = w_in_shift;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: an MSB-first and an LSB-first instance driven by the
// same inputs, checked every cycle against a bit-queue model and a word
// scoreboard that reassembles each serial word like the receiver would.
module tb_piso_shift_tx;
  import piso_shift_tx_pkg::*;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         ce = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;

  logic   lr_m, so_m, sv_m, last_m, busy_m;
  logic   lr_l, so_l, sv_l, last_l, busy_l;
  state_t st_m, st_l;

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_msb (
    .clk(clk), .rst(rst), .ce(ce), .load_valid(load_valid), .load_data(load_data),
    .load_ready(lr_m), .so(so_m), .so_valid(sv_m), .last(last_m), .busy(busy_m),
    .dbg_state(st_m)
  );

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .ce(ce), .load_valid(load_valid), .load_data(load_data),
    .load_ready(lr_l), .so(so_l), .so_valid(sv_l), .last(last_l), .busy(busy_l),
    .dbg_state(st_l)
  );

  // ---------------- reference model / scoreboard ----------------
  // Each queue holds the bits still to appear on so, front = bit on so now.
  bit           bq_m[$];
  bit           bq_l[$];
  logic [W-1:0] exp_m[$];
  logic [W-1:0] exp_l[$];
  logic [W-1:0] rx_m, rx_l;
  int           nb_m, nb_l;
  int           n_cmp = 0;
  int           n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    bq_m.delete(); bq_l.delete();
    exp_m.delete(); exp_l.delete();
    nb_m = 0; nb_l = 0; rx_m = '0; rx_l = '0;
  endtask

  task automatic check_outputs();
    logic lr_exp;
    lr_exp = rst & ce & (bq_m.size() <= 1);
    chk("so_m",    32'(so_m),   32'(bq_m.size() > 0 ? bq_m[0] : 1'b1));
    chk("valid_m", 32'(sv_m),   32'(bq_m.size() > 0));
    chk("last_m",  32'(last_m), 32'(bq_m.size() == 1));
    chk("busy_m",  32'(busy_m), 32'(bq_m.size() > 0));
    chk("ready_m", 32'(lr_m),   32'(lr_exp));
    chk("state_m", 32'(st_m),   32'(bq_m.size() > 0 ? ST_SHIFT : ST_IDLE));
    chk("so_l",    32'(so_l),   32'(bq_l.size() > 0 ? bq_l[0] : 1'b1));
    chk("valid_l", 32'(sv_l),   32'(bq_l.size() > 0));
    chk("last_l",  32'(last_l), 32'(bq_l.size() == 1));
    chk("busy_l",  32'(busy_l), 32'(bq_l.size() > 0));
    chk("ready_l", 32'(lr_l),   32'(lr_exp));
  endtask

  // Receiver-side view: shift in so on each enabled edge while a bit is valid.
  task automatic sample_rx();
    logic [W-1:0] e;
    if (rst && ce && sv_m) begin
      rx_m = {rx_m[W-2:0], so_m};
      nb_m++;
      if (nb_m == W) begin
        nb_m = 0;
        if (exp_m.size() == 0) begin
          n_cmp++; n_fail++;
          $error("FAIL word_m: observed=%0h expected=none", rx_m);
        end else begin
          e = exp_m.pop_front();
          chk("word_m", 32'(rx_m), 32'(e));
        end
      end
    end
    if (rst && ce && sv_l) begin
      rx_l = {so_l, rx_l[W-1:1]};
      nb_l++;
      if (nb_l == W) begin
        nb_l = 0;
        if (exp_l.size() == 0) begin
          n_cmp++; n_fail++;
          $error("FAIL word_l: observed=%0h expected=none", rx_l);
        end else begin
          e = exp_l.pop_front();
          chk("word_l", 32'(rx_l), 32'(e));
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge: drive, check, then advance one clock.
  task automatic step(input logic c, input logic v, input logic [W-1:0] d);
    logic acc;
    ce = c; load_valid = v; load_data = d;
    #1;
    check_outputs();
    sample_rx();
    acc = rst & c & v & (bq_m.size() <= 1);
    @(posedge clk);
    if (rst && c) begin
      if (bq_m.size() > 0) void'(bq_m.pop_front());
      if (bq_l.size() > 0) void'(bq_l.pop_front());
      if (acc) begin
        for (int i = W - 1; i >= 0; i--) bq_m.push_back(d[i]);
        for (int i = 0; i < W; i++) bq_l.push_back(d[i]);
        exp_m.push_back(d);
        exp_l.push_back(d);
      end
    end
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic async_reset();
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    check_outputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    @(posedge clk); #1;

    // Reset held with ce=1 and load_valid=1: nothing accepted.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'hF);
    rst = 1'b1;
    step(1'b1, 1'b0, 4'h0);

    // Single word 1011.
    step(1'b1, 1'b1, 4'b1011);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'h0);

    // Back-to-back A then 5 with load_valid held.
    step(1'b1, 1'b1, 4'hA);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'h5);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'h0);

    // ce gating on word 1100; load_valid offered while ce=0 only.
    step(1'b1, 1'b1, 4'b1100);
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h7);
    step(1'b0, 1'b1, 4'h7);
    step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h7);
    step(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0);

    // Word 0001: LSB instance sends 1,0,0,0.
    step(1'b1, 1'b1, 4'b0001);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'h0);

    // Reset after two bits of F, then 0 must go out clean.
    step(1'b1, 1'b1, 4'hF);
    step(1'b1, 1'b0, 4'h0);
    async_reset();
    step(1'b1, 1'b1, 4'hF);
    rst = 1'b1;
    step(1'b1, 1'b1, 4'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'h0);

    // Randomized traffic with gated clock enable and occasional reset.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset();
        step(1'b1, 1'b1, W'($urandom_range(0, 15)));
        rst = 1'b1;
      end else begin
        step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             W'($urandom_range(0, 15)));
      end
    end

    // Drain and confirm every accepted word came out.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'h0);
    chk("drain_m", 32'(exp_m.size()), 32'd0);
    chk("drain_l", 32'(exp_l.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog: the directed/random sequence is bounded; this only guards hangs.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
